cbd_poly_sampler: RTL
=====================

# cbd_poly_sampler

Controller that turns a stream of XOF output words into one polynomial of centered-binomial (η = 2) coefficients for the KEM. It splits each accepted word into 4-bit nibbles and passes them one per cycle through a `cbd` instance. It reduces each raw coefficient into [0, KEM_Q−1] and writes it to polynomial RAM with a running address. It sits between the SHAKE/XOF output buffer (upstream) and the polynomial memory used by NTT and arithmetic (downstream).

## Interface
- KEM_Q, 7681, modulus.
- N, 64, coefficients per polynomial; N must be a multiple of W/4.
- W, 64, input word width; multiple of 4.
- COEFF_W, 13, coefficient width.
- AW, $clog2(N), address width.

- clk  in  1  clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to sample one polynomial. Ignored unless the block is in IDLE.
- busy  out  1  high from the cycle after an accepted start up to, but not including, the done cycle.
- done  out  1  one-cycle pulse when the polynomial is complete.
- in_word  in  W  XOF data; nibble k = in_word[4k+3:4k]; k = 0 is consumed first.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts in_word this cycle.
- coeff_we  out  1  write strobe to polynomial RAM.
- coeff_addr  out  AW  write address, 0..N−1.
- coeff_out  out  COEFF_W  reduced coefficient.

## Operation
- FSM states: IDLE, LOAD, EMIT, FIN.
- **IDLE**
  - start = 1 → LOAD.
  - Clear the coefficient counter and the nibble counter.
- **LOAD**
  - in_ready = 1; in_ready is 0 in every other state.
  - On in_valid & in_ready: capture in_word into a W-bit shift register and go to EMIT.
  - With in_valid low the FSM waits indefinitely and issues no writes.
- **EMIT** (one cycle per nibble)
  - Present shreg[3:0] to `cbd`, which returns raw = (a[0]+a[1]) + KEM_Q − (a[2]+a[3]), in the range KEM_Q−2..KEM_Q+2.
  - Reduce: coeff = raw ≥ KEM_Q ? raw − KEM_Q : raw.
  - Only results {0, 1, 2, KEM_Q−1, KEM_Q−2} can occur.
  - Register the coefficient with coeff_we = 1 and coeff_addr = coefficient count.
  - Shift shreg right by 4, then increment the nibble count and the coefficient count.
  - After nibble W/4−1:
    - go to FIN if the coefficient count has reached N;
    - otherwise go to LOAD.
- **FIN**
  - Go to IDLE next cycle.
  - done is registered so that it pulses exactly the cycle after the final coeff_we.
- Arithmetic:
  - the positive and negative sums are 2 bits each;
  - the raw sum is COEFF_W bits, with no overflow since KEM_Q+2 < 2^13;
  - the coefficient counter is AW+1 bits;
  - coeff_addr never wraps within a polynomial.
- start while busy is ignored; the in-flight polynomial continues unaffected.
- rst at any point:
  - next state is IDLE;
  - counters and shift register cleared;
  - coeff_we, done, busy, in_ready all 0;
  - RAM writes already issued are not undone, and the partial polynomial is abandoned;
  - no done pulse is issued for it.
- Reset values of every output: busy = 0, done = 0, in_ready = 0, coeff_we = 0, coeff_addr = 0, coeff_out = 0.

## Timing
- start sampled in cycle 0 → LOAD and in_ready = 1 in cycle 1.
- Handshake in cycle c → EMIT in cycles c+1..c+W/4; coeff_we high in cycles c+2..c+W/4+1 with consecutive addresses. This is one cycle of output register latency.
- The cycle after the last EMIT is LOAD: in_ready = 1 while the last write of the previous word is on the outputs.
- Per-word cost is W/4 + 1 cycles with in_valid held high.
- Defaults (N = 64, W = 64), in_valid always high:
  - handshakes in cycles 1, 18, 35, 52;
  - writes in cycles 3..18, 20..35, 37..52, 54..69;
  - done in cycle 70;
  - busy high in cycles 1..69.
- in_word must remain stable only in the handshake cycle.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0, no coeff_we.
- start; word 0xFEDCBA9876543210 followed by three all-zero words → addresses 0..15 receive 0,1,1,2,7680,0,0,1,7680,0,0,1,7679,7680,7680,0; addresses 16..63 receive 0; done in cycle 70; exactly 64 writes.
- in_valid dropped for 10 cycles before word 2 → no writes during the gap; addresses stay contiguous; done is delayed by exactly 10 cycles.
- start pulsed during cycle 30 of an active run → ignored; one done; 64 writes.
- rst asserted in cycle 25 of a run, then a fresh start → outputs 0 the cycle after rst; new run begins at address 0 and completes normally with done.
- Random words, 200 polynomials → each coefficient equals the reference model (popcount(n[1:0]) − popcount(n[3:2])) mod 7681; address order 0..63; one done per start.

Source files
------------

// File: rtl/cbd_poly_sampler.sv
// Centered-binomial (eta = 2) polynomial sampler: turns XOF words into N reduced
// coefficients, one nibble per cycle, written to polynomial RAM at running addresses.

module cbd #(
    parameter int KEM_Q   = 7681,
    parameter int COEFF_W = 13
) (
    input  logic [3:0]         a_i,
    output logic [COEFF_W-1:0] raw_o
);
    logic [1:0] pos;
    logic [1:0] neg;

    assign pos   = {1'b0, a_i[0]} + {1'b0, a_i[1]};
    assign neg   = {1'b0, a_i[2]} + {1'b0, a_i[3]};
    // Offset by KEM_Q so the difference stays non-negative: range KEM_Q-2..KEM_Q+2.
    assign raw_o = COEFF_W'(KEM_Q) + COEFF_W'(pos) - COEFF_W'(neg);
endmodule

module cbd_poly_sampler #(
    parameter int KEM_Q   = 7681,
    parameter int N       = 64,
    parameter int W       = 64,
    parameter int COEFF_W = 13,
    parameter int AW      = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic [W-1:0]       in_word,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               coeff_we,
    output logic [AW-1:0]      coeff_addr,
    output logic [COEFF_W-1:0] coeff_out,
    output logic [1:0]         dbg_state
);
    localparam int NIB = W / 4;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} state_t;

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are
    // both high; in_ready is high only in LOAD, and in_word need only be stable then.
    state_t             state_q, state_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic [NW-1:0]      nib_q, nib_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [COEFF_W-1:0] coeff_q, coeff_d;
    logic               done_q, done_d;

    logic [COEFF_W-1:0] raw;
    logic [COEFF_W-1:0] red;
    logic               last_nib;

    cbd #(.KEM_Q(KEM_Q), .COEFF_W(COEFF_W)) u_cbd (
        .a_i   (shreg_q[3:0]),
        .raw_o (raw)
    );

    assign red      = (raw >= COEFF_W'(KEM_Q)) ? raw - COEFF_W'(KEM_Q) : raw;
    assign last_nib = (nib_q == NW'(NIB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            nib_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            coeff_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            nib_q   <= nib_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            coeff_q <= coeff_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        nib_d   = nib_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        coeff_d = coeff_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                nib_d = '0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (in_valid) begin
                    shreg_d = in_word;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                we_d    = 1'b1;
                addr_d  = cnt_q[AW-1:0];
                coeff_d = red;
                shreg_d = shreg_q >> 4;
                nib_d   = nib_q + NW'(1);
                cnt_d   = cnt_q + (AW+1)'(1);
                if (last_nib) begin
                    nib_d   = '0;
                    state_d = (cnt_q + (AW+1)'(1) == (AW+1)'(N)) ? FIN : LOAD;
                end
            end
            FIN: begin
                // Registered, so done lands the cycle after the final write.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign in_ready   = (state_q == LOAD);
    assign done       = done_q;
    assign coeff_we   = we_q;
    assign coeff_addr = addr_q;
    assign coeff_out  = coeff_q;
    assign dbg_state  = state_q;
endmodule
